// File: rtl/line_pkg.sv
// Shared types and defaults for the Bresenham line rasteriser.
package line_pkg;

   localparam int unsigned DEFAULT_COORD_W = 11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_DRAW,
      S_DONE
   } line_state_t;

   // Error-term type: two bits wider than a coordinate so 2*err never wraps.
   typedef logic signed [DEFAULT_COORD_W+1:0] line_err_t;

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham iteration: advances the current point toward the end point
// and returns the updated error term. Purely combinational.
module bresenham_step #(
   parameter int unsigned COORD_W = 11
) (
   input  logic [COORD_W-1:0]        cur_x,
   input  logic [COORD_W-1:0]        cur_y,
   input  logic signed [COORD_W+1:0] err,
   input  logic signed [COORD_W+1:0] dx,
   input  logic signed [COORD_W+1:0] dy,
   input  logic                      sx,
   input  logic                      sy,
   output logic [COORD_W-1:0]        next_x,
   output logic [COORD_W-1:0]        next_y,
   output logic signed [COORD_W+1:0] next_err
);

   logic signed [COORD_W+1:0] e2;
   logic                      step_x;
   logic                      step_y;

   // Both axis decisions look at the error before this step's updates.
   always_comb begin
      e2       = err <<< 1;
      step_x   = (e2 >= dy);
      step_y   = (e2 <= dx);
      next_err = err;
      next_x   = cur_x;
      next_y   = cur_y;
      if (step_x) begin
         next_err = next_err + dy;
         next_x   = sx ? cur_x + COORD_W'(1) : cur_x - COORD_W'(1);
      end
      if (step_y) begin
         next_err = next_err + dx;
         next_y   = sy ? cur_y + COORD_W'(1) : cur_y - COORD_W'(1);
      end
   end

endmodule

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: latches two endpoints on start and emits one
// pixel coordinate per clock until the end point has been produced.
module line_drawer
   import line_pkg::*;
#(
   parameter int unsigned COORD_W = DEFAULT_COORD_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               pixel_valid,
   output logic               busy,
   output logic               done
);

   localparam int unsigned EW = COORD_W + 2;
   typedef logic signed [EW-1:0] err_t;

   line_state_t        state;
   line_state_t        state_next;

   logic [COORD_W-1:0] beg_x;
   logic [COORD_W-1:0] beg_y;
   logic [COORD_W-1:0] end_x;
   logic [COORD_W-1:0] end_y;
   logic [COORD_W-1:0] cur_x;
   logic [COORD_W-1:0] cur_y;
   logic [COORD_W-1:0] next_x;
   logic [COORD_W-1:0] next_y;

   err_t               dx;
   err_t               dy;
   err_t               err;
   err_t               next_err;
   err_t               diff_x;
   err_t               diff_y;
   err_t               dx_init;
   err_t               dy_init;

   logic               sx;
   logic               sy;
   logic               at_end;

   // Setup arithmetic on the latched endpoints, used only in S_INIT.
   always_comb begin
      diff_x  = $signed({2'b00, end_x}) - $signed({2'b00, beg_x});
      diff_y  = $signed({2'b00, end_y}) - $signed({2'b00, beg_y});
      dx_init = diff_x[EW-1] ? -diff_x : diff_x;
      dy_init = diff_y[EW-1] ? diff_y : -diff_y;
      at_end  = (cur_x == end_x) && (cur_y == end_y);
   end

   bresenham_step #(
      .COORD_W (COORD_W)
   ) u_step (
      .cur_x    (cur_x),
      .cur_y    (cur_y),
      .err      (err),
      .dx       (dx),
      .dy       (dy),
      .sx       (sx),
      .sy       (sy),
      .next_x   (next_x),
      .next_y   (next_y),
      .next_err (next_err)
   );

   // State register plus endpoint, step and current-point registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         beg_x <= '0;
         beg_y <= '0;
         end_x <= '0;
         end_y <= '0;
         cur_x <= '0;
         cur_y <= '0;
         dx    <= '0;
         dy    <= '0;
         err   <= '0;
         sx    <= 1'b0;
         sy    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (start) begin
                  beg_x <= x0;
                  beg_y <= y0;
                  end_x <= x1;
                  end_y <= y1;
               end
            end
            S_INIT: begin
               dx    <= dx_init;
               dy    <= dy_init;
               err   <= dx_init + dy_init;
               sx    <= (beg_x < end_x);
               sy    <= (beg_y < end_y);
               cur_x <= beg_x;
               cur_y <= beg_y;
            end
            S_DRAW: begin
               if (!at_end) begin
                  cur_x <= next_x;
                  cur_y <= next_y;
                  err   <= next_err;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_next  = state;
      pixel_valid = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_INIT;
         end
         S_INIT: begin
            busy       = 1'b1;
            state_next = S_DRAW;
         end
         S_DRAW: begin
            busy        = 1'b1;
            pixel_valid = 1'b1;
            if (at_end) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign x = cur_x;
   assign y = cur_y;

endmodule

// File: tb/tb_line_drawer.sv
// Self-checking bench for line_drawer against an integer Bresenham model.
module tb_line_drawer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] x0, y0, x1, y1;
   logic [10:0] x, y;
   logic        pixel_valid, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   int got_x[$], got_y[$];
   int ref_x[$], ref_y[$];

   int r_lat, r_busy;
   bit r_done_ok, r_done_single, r_timeout, r_post_busy, r_gap;

   line_drawer #(.COORD_W(11)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .x0          (x0),
      .y0          (y0),
      .x1          (x1),
      .y1          (y1),
      .x           (x),
      .y           (y),
      .pixel_valid (pixel_valid),
      .busy        (busy),
      .done        (done)
   );

   // 50 MHz-style free-running clock.
   always #10 clk = ~clk;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference rasteriser: textbook integer Bresenham filling ref_x/ref_y.
   task automatic ref_line(input int ax0, input int ay0, input int ax1, input int ay1);
      int cx, cy, ddx, ddy, stx, sty, e, e2;
      cx = ax0; cy = ay0;
      ddx = iabs(ax1 - ax0);
      ddy = -iabs(ay1 - ay0);
      stx = (ax0 < ax1) ? 1 : -1;
      sty = (ay0 < ay1) ? 1 : -1;
      e = ddx + ddy;
      ref_x.delete(); ref_y.delete();
      for (int guard = 0; guard < 5000; guard++) begin
         ref_x.push_back(cx);
         ref_y.push_back(cy);
         if (cx == ax1 && cy == ay1) break;
         e2 = 2 * e;
         if (e2 >= ddy) begin e += ddy; cx += stx; end
         if (e2 <= ddx) begin e += ddx; cy += sty; end
      end
   endtask

   // Index of first difference between captured and reference pixels; -1 if equal.
   function automatic int first_diff();
      int n;
      n = (got_x.size() < ref_x.size()) ? got_x.size() : ref_x.size();
      for (int i = 0; i < n; i++)
         if (got_x[i] != ref_x[i] || got_y[i] != ref_y[i]) return i;
      if (got_x.size() != ref_x.size()) return n;
      return -1;
   endfunction

   // True when every consecutive captured pixel is a distinct 8-neighbour.
   function automatic bit connected();
      for (int i = 1; i < got_x.size(); i++) begin
         if (iabs(got_x[i] - got_x[i-1]) > 1 || iabs(got_y[i] - got_y[i-1]) > 1) return 0;
         if (got_x[i] == got_x[i-1] && got_y[i] == got_y[i-1]) return 0;
      end
      return 1;
   endfunction

   // Issue one line and capture its pixels; optional start pulse mid-line or on done.
   task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int inject_cyc, input int ix0, input int iy0,
                           input int ix1, input int iy1, input bit start_on_done);
      int cyc;
      bit ended, prev_valid;
      got_x.delete(); got_y.delete();
      r_lat = -1; r_busy = 0; r_done_ok = 0; r_done_single = 0;
      r_timeout = 0; r_post_busy = 0; r_gap = 0;
      @(negedge clk);
      x0 = 11'(ax0); y0 = 11'(ay0); x1 = 11'(ax1); y1 = 11'(ay1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; ended = 0; prev_valid = 0;
      while (!ended && cyc < 3000) begin
         if (busy) r_busy++;
         if (pixel_valid) begin
            if (r_lat < 0) r_lat = cyc;
            else if (!prev_valid) r_gap = 1;
            got_x.push_back(int'(x));
            got_y.push_back(int'(y));
         end
         if (done) begin
            ended = 1;
            r_done_ok = prev_valid && !pixel_valid && !busy;
         end
         prev_valid = pixel_valid;
         start = 1'b0;
         if (cyc == inject_cyc || (ended && start_on_done)) begin
            start = 1'b1;
            x0 = 11'(ix0); y0 = 11'(iy0); x1 = 11'(ix1); y1 = 11'(iy1);
         end
         if (!ended) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!ended) r_timeout = 1;
      @(negedge clk);
      start = 1'b0;
      r_done_single = !done;
      r_post_busy = busy;
      if (r_timeout) begin
         reset = 1'b1;
         repeat (2) @(negedge clk);
         reset = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1;
      x0 = 11'd5; y0 = 11'd6; x1 = 11'd7; y1 = 11'd8;
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if ({pixel_valid, busy, done, x, y} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_hold: pv=%b busy=%b done=%b x=%0d y=%0d, required all 0",
                     pixel_valid, busy, done, x, y);
         end
      end
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({pixel_valid, busy, done} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_release: pv=%b busy=%b done=%b, required 000", pixel_valid, busy, done);
      end
   endtask

   task automatic test_horizontal();
      run_line(0, 0, 4, 0, -1, 0, 0, 0, 0, 0);
      ref_line(0, 0, 4, 0);
      n_cmp++;
      if (first_diff() != -1 || got_x.size() != 5) begin
         n_err++;
         $display("FAIL horiz_seq: %0d pixels diff at %0d, required 5 pixels (0..4,0)",
                  got_x.size(), first_diff());
      end
      n_cmp++;
      if (r_lat != 2 || r_gap) begin
         n_err++;
         $display("FAIL horiz_latency: first at %0d gap=%b, required 2 gap=0", r_lat, r_gap);
      end
      n_cmp++;
      if (!r_done_ok || !r_done_single || r_timeout) begin
         n_err++;
         $display("FAIL horiz_done: ok=%b single=%b timeout=%b, required 1 1 0",
                  r_done_ok, r_done_single, r_timeout);
      end
   endtask

   task automatic test_steep();
      int ysteps, xsteps;
      run_line(5, 7, 3, 1, -1, 0, 0, 0, 0, 0);
      ref_line(5, 7, 3, 1);
      ysteps = 0; xsteps = 0;
      for (int i = 1; i < got_x.size(); i++) begin
         if (got_y[i] == got_y[i-1] - 1) ysteps++;
         if (got_x[i] == got_x[i-1] - 1) xsteps++;
      end
      n_cmp++;
      if (got_x.size() != 7 || ysteps != 6 || xsteps != 2) begin
         n_err++;
         $display("FAIL steep_shape: n=%0d ysteps=%0d xsteps=%0d, required 7 6 2",
                  got_x.size(), ysteps, xsteps);
      end
      n_cmp++;
      if (got_x.size() == 0 || got_x[$] != 3 || got_y[$] != 1) begin
         n_err++;
         $display("FAIL steep_last: got %0d pixels, required last (3,1)", got_x.size());
      end
      n_cmp++;
      if (first_diff() != -1) begin
         n_err++;
         $display("FAIL steep_seq: diff at index %0d, required none", first_diff());
      end
   endtask

   task automatic test_single();
      run_line(10, 10, 10, 10, -1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (got_x.size() != 1 || (got_x.size() == 1 && (got_x[0] != 10 || got_y[0] != 10))) begin
         n_err++;
         $display("FAIL single_pixel: %0d pixels, required one at (10,10)", got_x.size());
      end
      n_cmp++;
      if (r_busy != 2 || !r_done_ok || !r_done_single) begin
         n_err++;
         $display("FAIL single_busy: busy=%0d done_ok=%b single=%b, required 2 1 1",
                  r_busy, r_done_ok, r_done_single);
      end
   endtask

   task automatic test_busy_ignore();
      run_line(2, 3, 20, 11, 4, 100, 200, 300, 50, 0);
      ref_line(2, 3, 20, 11);
      n_cmp++;
      if (first_diff() != -1 || r_timeout) begin
         n_err++;
         $display("FAIL busy_start_seq: diff at %0d n=%0d, required %0d matching pixels",
                  first_diff(), got_x.size(), ref_x.size());
      end
      n_cmp++;
      if (r_post_busy) begin
         n_err++;
         $display("FAIL busy_start_after: busy=%b, required 0", r_post_busy);
      end
      run_line(30, 30, 27, 33, -1, 1, 1, 9, 9, 1);
      n_cmp++;
      if (r_post_busy || !r_done_ok) begin
         n_err++;
         $display("FAIL done_start: busy=%b done_ok=%b, required busy 0 done_ok 1",
                  r_post_busy, r_done_ok);
      end
   endtask

   task automatic test_reset_mid();
      int cnt, cyc;
      bit quiet;
      @(negedge clk);
      x0 = 11'd0; y0 = 11'd0; x1 = 11'd639; y1 = 11'd479; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0; cyc = 0;
      while (cnt < 3 && cyc < 50) begin
         if (pixel_valid) cnt++;
         if (cnt < 3) begin @(negedge clk); cyc++; end
      end
      reset = 1'b1;
      x0 = 11'd7; y0 = 11'd9; x1 = 11'd12; y1 = 11'd3;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if (cnt != 3 || {pixel_valid, busy, done, x, y} !== 25'd0) begin
         n_err++;
         $display("FAIL reset_mid: cnt=%0d pv=%b busy=%b x=%0d y=%0d, required 3 0 0 0 0",
                  cnt, pixel_valid, busy, x, y);
      end
      quiet = 1;
      repeat (3) begin
         @(negedge clk);
         if (pixel_valid || busy) quiet = 0;
      end
      n_cmp++;
      if (!quiet) begin
         n_err++;
         $display("FAIL reset_mid_idle: activity seen after reset, required none");
      end
      run_line(7, 9, 12, 3, -1, 0, 0, 0, 0, 0);
      ref_line(7, 9, 12, 3);
      n_cmp++;
      if (first_diff() != -1 || r_lat != 2) begin
         n_err++;
         $display("FAIL reset_mid_restart: diff at %0d lat=%0d, required none and 2",
                  first_diff(), r_lat);
      end
   endtask

   task automatic test_random();
      int ax0, ay0, ax1, ay1, want;
      for (int k = 0; k < 200; k++) begin
         ax0 = $urandom_range(0, 639); ay0 = $urandom_range(0, 479);
         ax1 = $urandom_range(0, 639); ay1 = $urandom_range(0, 479);
         if (k % 10 == 0) ay1 = ay0;
         if (k % 10 == 1) ax1 = ax0;
         run_line(ax0, ay0, ax1, ay1, -1, 0, 0, 0, 0, 0);
         ref_line(ax0, ay0, ax1, ay1);
         want = ((iabs(ax1 - ax0) > iabs(ay1 - ay0)) ? iabs(ax1 - ax0) : iabs(ay1 - ay0)) + 1;
         n_cmp++;
         if (got_x.size() != want || r_timeout) begin
            n_err++;
            $display("FAIL rnd_count #%0d (%0d,%0d)->(%0d,%0d): %0d pixels timeout=%b, required %0d",
                     k, ax0, ay0, ax1, ay1, got_x.size(), r_timeout, want);
         end
         n_cmp++;
         if (got_x.size() == 0 || got_x[0] != ax0 || got_y[0] != ay0 ||
             got_x[$] != ax1 || got_y[$] != ay1) begin
            n_err++;
            $display("FAIL rnd_endpoints #%0d: n=%0d, required first (%0d,%0d) last (%0d,%0d)",
                     k, got_x.size(), ax0, ay0, ax1, ay1);
         end
         n_cmp++;
         if (!connected()) begin
            n_err++;
            $display("FAIL rnd_connect #%0d: path not 8-connected, required 8-connected", k);
         end
         n_cmp++;
         if (first_diff() != -1) begin
            n_err++;
            $display("FAIL rnd_seq #%0d: diff at %0d, required match with model", k, first_diff());
         end
         n_cmp++;
         if (r_lat != 2 || r_gap || !r_done_ok || !r_done_single) begin
            n_err++;
            $display("FAIL rnd_timing #%0d: lat=%0d gap=%b done_ok=%b single=%b, required 2 0 1 1",
                     k, r_lat, r_gap, r_done_ok, r_done_single);
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      test_reset();
      test_horizontal();
      test_steep();
      test_single();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
